// File: rtl/rotl_serial_if.sv
// Request/result handshake bundle for rotl_serial.
// ROTL_LOGICAL_SHIFT_EN adds the in_logical request bit.
interface rotl_serial_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
`ifdef ROTL_LOGICAL_SHIFT_EN
    logic             in_logical;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

`ifdef ROTL_LOGICAL_SHIFT_EN
    modport slave  (input  in_valid, output in_ready, input  in_data, input  in_amt,
                    input  in_logical,
                    output out_valid, input  out_ready, output out_data);
    modport master (output in_valid, input  in_ready, output in_data, output in_amt,
                    output in_logical,
                    input  out_valid, output out_ready, input  out_data);
`else
    modport slave  (input  in_valid, output in_ready, input  in_data, input  in_amt,
                    output out_valid, input  out_ready, output out_data);
    modport master (output in_valid, input  in_ready, output in_data, output in_amt,
                    input  out_valid, output out_ready, input  out_data);
`endif
endinterface

// File: rtl/rotl_serial.sv
// Multi-cycle rotate-left unit, one bit position per clock, valid/ready on both sides.
// Define ROTL_LOGICAL_SHIFT_EN to add a per-request zero-fill logical shift mode.
module rotl_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input  logic         clk,
    input  logic         rst,
    rotl_serial_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SHW-1:0]   amt_eff_c;
    logic [WIDTH-1:0] step_c;
    logic             accept_c;

    // Amount reduced mod WIDTH; a constant modulus, so it folds to truncation for powers of 2.
    assign amt_eff_c = SHW'(32'(bus.in_amt) % WIDTH);
    assign accept_c  = bus.in_valid && in_ready_q;

`ifdef ROTL_LOGICAL_SHIFT_EN
    logic logical_q, logical_d;
    assign step_c = logical_q ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
`else
    assign step_c = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = (amt_eff_c == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
`ifdef ROTL_LOGICAL_SHIFT_EN
        logical_d   = logical_q;
`endif
        if (state_q == IDLE && accept_c) begin
            shreg_d = bus.in_data;
            cnt_d   = amt_eff_c;
`ifdef ROTL_LOGICAL_SHIFT_EN
            logical_d = bus.in_logical;
`endif
        end else if (state_q == SHIFT) begin
            shreg_d = step_c;
            cnt_d   = cnt_q - SHW'(1);
        end
        // Result is loaded only on entry to DONE, so it stays put after the handshake.
        if (state_d == DONE && state_q != DONE) out_data_d = shreg_d;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef ROTL_LOGICAL_SHIFT_EN
            logical_q   <= 1'b0;
`endif
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef ROTL_LOGICAL_SHIFT_EN
            logical_q   <= logical_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_rotl_serial.sv
// Directed bench for rotl_serial: latency, boundaries, backpressure, reset abort, rotr inverse sweep.
module tb_rotl_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    rotl_serial_if #(.WIDTH(8), .SHW(3)) bus ();
    rotl_serial #(.WIDTH(8), .SHW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] x, input int s);
        logic [15:0] w;
        w = {x, x} >> s;
        return w[7:0];
    endfunction

    // Issue one request; cyc returns cycles from acceptance edge until out_valid is seen.
    task automatic do_req(input logic [7:0] d, input logic [2:0] a, input logic lg, output int cyc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
`ifdef ROTL_LOGICAL_SHIFT_EN
        bus.in_logical = lg;
`endif
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin @(negedge clk); cyc++; end
        if (cyc >= 20) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_amt   = ~a;
`ifdef ROTL_LOGICAL_SHIFT_EN
        bus.in_logical = ~lg;
`endif
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          seen;
        int          bad;
        int          guard;
        logic        done;
        logic [7:0]  got;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
`ifdef ROTL_LOGICAL_SHIFT_EN
        bus.in_logical = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);

        // Reset during SHIFT aborts the operation
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_amt = 3'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data", 32'(bus.out_data), 32'h00);
        seen = 0;
        repeat (12) begin @(negedge clk); if (bus.out_valid) seen++; end
        check("abort_no_result", 32'(seen), 32'd0);

        // Basic
        do_req(8'b1000_0001, 3'd1, 1'b0, cyc);
        check("lat_amt1", 32'(cyc), 32'd2);
        check("data_81_r1", 32'(bus.out_data), 32'h03);
        take();
        check("hs_out_valid_low", 32'(bus.out_valid), 32'd0);
        check("hs_in_ready_high", 32'(bus.in_ready), 32'd1);
        do_req(8'hB4, 3'd4, 1'b0, cyc);
        check("lat_amt4", 32'(cyc), 32'd5);
        check("data_B4_r4", 32'(bus.out_data), 32'h4B);
        take();

        // Boundaries
        do_req(8'h3C, 3'd0, 1'b0, cyc);
        check("lat_amt0", 32'(cyc), 32'd1);
        check("data_3C_r0", 32'(bus.out_data), 32'h3C);
        take();
        do_req(8'h01, 3'd7, 1'b0, cyc);
        check("lat_amt7", 32'(cyc), 32'd8);
        check("data_01_r7", 32'(bus.out_data), 32'h80);
        take();

        // Backpressure with an ignored request pulse
        do_req(8'h5A, 3'd2, 1'b0, cyc);
        check("lat_bp", 32'(cyc), 32'd3);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== 8'h69 || bus.in_ready) bad++;
            bus.in_valid = (i == 1);
            bus.in_data  = 8'hFF;
            bus.in_amt   = 3'd0;
        end
        check("bp_stable", 32'(bad), 32'd0);
        take();
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_data_kept", 32'(bus.out_data), 32'h69);
        seen = 0;
        repeat (4) begin @(negedge clk); if (bus.out_valid) seen++; end
        check("bp_pulse_ignored", 32'(seen), 32'd0);

`ifdef ROTL_LOGICAL_SHIFT_EN
        do_req(8'hF1, 3'd4, 1'b1, cyc);
        check("lat_logical", 32'(cyc), 32'd5);
        check("data_F1_lsl4", 32'(bus.out_data), 32'h10);
        take();
        do_req(8'hF1, 3'd4, 1'b0, cyc);
        check("data_F1_rotl4", 32'(bus.out_data), 32'h1F);
        take();
`endif

        // Inverse of rotate-right for every word and amount, random backpressure
        for (int x = 0; x < 256; x++) begin
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = rotr(8'(x), s);
                bus.in_amt   = 3'(s);
`ifdef ROTL_LOGICAL_SHIFT_EN
                bus.in_logical = 1'b0;
`endif
                guard = 0;
                while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                done = 1'b0;
                got  = '0;
                guard = 0;
                while (!done && guard < 60) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                    if (bus.out_valid && bus.out_ready) begin
                        got  = bus.out_data;
                        done = 1'b1;
                    end
                    @(posedge clk); #1;
                    guard++;
                end
                bus.out_ready = 1'b0;
                if (!done) check("inv_timeout", 32'(done), 32'd1);
                else       check($sformatf("inv_x%0h_s%0d", x, s), 32'(got), 32'(x));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
